// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, drives a 1-cycle ROM and queues {instr, pc} pairs for decode.
// Latency: a request reaches the head two edges after it is issued. Backpressure: requests stop when queued plus in-flight entries reach DEPTH.
// The optional statistics counters are enabled by defining FETCH_STATS_EN.
module fetch_queue #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 9,
  parameter int DEPTH   = 4
) (
  input  logic               CLK,
  input  logic               Init,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch,
  input  logic [PC_W-1:0]    target,
  input  logic               halt,
  output logic               haltProgram
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]        fetch_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  logic [0:0]         state;
  logic [PC_W-1:0]    fetch_pc;
  logic [PC_W-1:0]    tag;
  logic               inflight;
  logic               kill;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [INSTR_W-1:0] mem_instr [DEPTH];
  logic [PC_W-1:0]    mem_pc    [DEPTH];
  logic [INSTR_W-1:0] last_instr;
  logic [PC_W-1:0]    last_pc;
  logic [CNT_W:0]     credit_used;
  logic               running;
  logic               do_halt;
  logic               do_branch;
  logic               flush;
  logic               push;
  logic               pop;

  assign running     = (state == RUN);
  assign credit_used = {1'b0, count} + (CNT_W+1)'(inflight);
  // Init gates the request so the ROM sees nothing while reset is held.
  assign imem_req    = running && !Init && (credit_used < (CNT_W+1)'(DEPTH));
  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0) && running;
  assign haltProgram = (state == HALTED);

  assign do_halt   = halt && instr_valid;
  assign do_branch = branch && running && !do_halt;
  assign flush     = do_halt || do_branch;
  // The response arriving on a flush edge belongs to the old stream and is dropped.
  assign push      = inflight && !kill && !flush;
  assign pop       = instr_valid && instr_ready && !branch && !halt;

  assign instr    = (count != '0) ? mem_instr[rd_ptr] : last_instr;
  assign instr_pc = (count != '0) ? mem_pc[rd_ptr]    : last_pc;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_instr[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]    <= tag;
    end
  end

  always_ff @(posedge CLK or posedge Init) begin
    if (Init) begin
      state      <= RUN;
      fetch_pc   <= '0;
      tag        <= '0;
      inflight   <= 1'b0;
      kill       <= 1'b0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      last_instr <= '0;
      last_pc    <= '0;
    end else begin
      inflight <= imem_req;
      kill     <= flush && (inflight || imem_req);
      if (imem_req) begin
        tag <= fetch_pc;
      end

      if (do_branch) begin
        fetch_pc <= target;
      end else if (imem_req) begin
        fetch_pc <= fetch_pc + PC_W'(1);
      end

      if (do_halt) begin
        state <= HALTED;
      end

      // Head is latched every cycle so instr/instr_pc hold once the queue drains.
      if (count != '0) begin
        last_instr <= mem_instr[rd_ptr];
        last_pc    <= mem_pc[rd_ptr];
      end

      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [CNT_W:0] flush_add;
  logic [16:0]    flush_sum;

  // Discards: everything queued plus the response landing on the flush edge, and later killed responses.
  assign flush_add = (flush ? ({1'b0, count} + (CNT_W+1)'(inflight && !kill)) : '0)
                   + (CNT_W+1)'(inflight && kill);
  assign flush_sum = {1'b0, flush_cnt} + 17'(flush_add);

  always_ff @(posedge CLK or posedge Init) begin
    if (Init) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else if (running) begin
      if (push && (fetch_cnt != 16'hFFFF)) begin
        fetch_cnt <= fetch_cnt + 16'd1;
      end
      flush_cnt <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, streaming, backpressure, branch, halt, PC wrap.
module tb_fetch_queue;

  logic        CLK = 1'b0;
  logic        Init = 1'b1;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [8:0]  imem_rdata = '0;
  logic [8:0]  instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        branch = 1'b0;
  logic [15:0] target = '0;
  logic        halt = 1'b0;
  logic        haltProgram;
`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt;
  logic [15:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fetch_queue dut (
    .CLK         (CLK),
    .Init        (Init),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .branch      (branch),
    .target      (target),
    .halt        (halt),
    .haltProgram (haltProgram)
`ifdef FETCH_STATS_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // ROM contents: word at address a is a[8:0]+1 (so ROM[0..5] = 0x001..0x006).
  always @(posedge CLK) begin
    if (imem_req) imem_rdata <= imem_addr[8:0] + 9'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_req",   32'(imem_req), 0);
    chk("rst_addr",  32'(imem_addr), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_pc",    32'(instr_pc), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_halt",  32'(haltProgram), 0);

    // 1: streaming from reset release, ready held high
    Init = 1'b0;
    tick(1);
    chk("t1_e1_valid", 32'(instr_valid), 0);
    chk("t1_e1_addr",  32'(imem_addr), 1);
    chk("t1_e1_req",   32'(imem_req), 1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("t1_valid", 32'(instr_valid), 1);
      chk("t1_pc",    32'(instr_pc), 32'(i));
      chk("t1_instr", 32'(instr), 32'(i + 1));
    end

    // 2: backpressure fills the queue, then drains in order
    Init = 1'b1;
    tick(1);
    Init = 1'b0;
    instr_ready = 1'b0;
    tick(4);
    chk("t2_full_req",  32'(imem_req), 0);
    chk("t2_full_addr", 32'(imem_addr), 4);
    tick(6);
    chk("t2_hold_valid", 32'(instr_valid), 1);
    chk("t2_hold_pc",    32'(instr_pc), 0);
    chk("t2_hold_instr", 32'(instr), 1);
    chk("t2_hold_req",   32'(imem_req), 0);
    chk("t2_hold_addr",  32'(imem_addr), 4);
    instr_ready = 1'b1;
    tick(1);
    chk("t2_d1_pc",  32'(instr_pc), 1);
    chk("t2_d1_req", 32'(imem_req), 1);
    tick(1);
    chk("t2_d2_pc", 32'(instr_pc), 2);
    tick(1);
    chk("t2_d3_pc", 32'(instr_pc), 3);
    tick(1);
    chk("t2_d4_pc",    32'(instr_pc), 4);
    chk("t2_d4_instr", 32'(instr), 5);
    chk("t2_d4_valid", 32'(instr_valid), 1);

    // 3: branch to 0x0040 while head is pc 2
    Init = 1'b1;
    tick(1);
    Init = 1'b0;
    tick(4);
    chk("t3_head_pc", 32'(instr_pc), 2);
    branch = 1'b1;
    target = 16'h0040;
    tick(1);
    branch = 1'b0;
    chk("t3_b1_valid", 32'(instr_valid), 0);
    chk("t3_b1_addr",  32'(imem_addr), 'h40);
    tick(1);
    chk("t3_b2_valid", 32'(instr_valid), 0);
    chk("t3_b2_pc",    32'(instr_pc), 2);
    tick(1);
    chk("t3_tgt_valid", 32'(instr_valid), 1);
    chk("t3_tgt_pc",    32'(instr_pc), 'h40);
    chk("t3_tgt_instr", 32'(instr), 'h41);
`ifdef FETCH_STATS_EN
    chk("t6_fetch_cnt", 32'(fetch_cnt), 4);
    chk("t6_flush_cnt", 32'(flush_cnt), 3);
`endif
    tick(1);
    chk("t3_next_pc",    32'(instr_pc), 'h41);
    chk("t3_next_instr", 32'(instr), 'h42);

    // 4: halt at head pc 5, then asynchronous Init mid-cycle
    Init = 1'b1;
    tick(1);
    Init = 1'b0;
    tick(7);
    chk("t4_head_pc", 32'(instr_pc), 5);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    chk("t4_h1_halt",  32'(haltProgram), 1);
    chk("t4_h1_req",   32'(imem_req), 0);
    chk("t4_h1_valid", 32'(instr_valid), 0);
    tick(1);
    chk("t4_h2_halt", 32'(haltProgram), 1);
    chk("t4_h2_req",  32'(imem_req), 0);
    #2 Init = 1'b1;
    #1;
    chk("t4_async_halt",  32'(haltProgram), 0);
    chk("t4_async_addr",  32'(imem_addr), 0);
    chk("t4_async_pc",    32'(instr_pc), 0);
    chk("t4_async_valid", 32'(instr_valid), 0);
    tick(1);
    Init = 1'b0;
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    chk("t4_idle_halt_ignored", 32'(haltProgram), 0);
    chk("t4_re_addr",           32'(imem_addr), 1);
    tick(1);
    chk("t4_re_valid", 32'(instr_valid), 1);
    chk("t4_re_pc",    32'(instr_pc), 0);
    chk("t4_re_instr", 32'(instr), 1);

    // 5: branch to 0xFFFE and wrap through zero
    branch = 1'b1;
    target = 16'hFFFE;
    tick(1);
    branch = 1'b0;
    chk("t5_b1_valid", 32'(instr_valid), 0);
    chk("t5_b1_addr",  32'(imem_addr), 'hFFFE);
    tick(1);
    chk("t5_b2_valid", 32'(instr_valid), 0);
    tick(1);
    chk("t5_w0_pc",    32'(instr_pc), 'hFFFE);
    chk("t5_w0_instr", 32'(instr), 'h1FF);
    tick(1);
    chk("t5_w1_pc",    32'(instr_pc), 'hFFFF);
    chk("t5_w1_instr", 32'(instr), 'h000);
    tick(1);
    chk("t5_w2_pc",    32'(instr_pc), 0);
    chk("t5_w2_instr", 32'(instr), 1);
    tick(1);
    chk("t5_w3_pc",    32'(instr_pc), 1);
    chk("t5_w3_instr", 32'(instr), 2);

    // halt and branch together: halt wins
    halt   = 1'b1;
    branch = 1'b1;
    target = 16'h0100;
    tick(1);
    halt   = 1'b0;
    branch = 1'b0;
    chk("hb_halt",  32'(haltProgram), 1);
    chk("hb_req",   32'(imem_req), 0);
    chk("hb_valid", 32'(instr_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
